// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multi-cycle RV32I controller: opcodes, FSM states, mux selects, ALU ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a. RISCV_BRANCH_EXT_EN widens the legal branch funct3 set.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } e_mcState;

    typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RD1 = 2'd2} e_aluSrcA;
    typedef enum logic [1:0] {SRCB_RD2 = 2'd0, SRCB_IMM = 2'd1, SRCB_CONST4 = 2'd2} e_aluSrcB;
    typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2} e_resultSrc;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } e_aluOp;

    // What the current state wants from the ALU: plain add, compare-subtract, or the decoded funct op.
    typedef enum logic [1:0] {ACLS_ADD = 2'd0, ACLS_SUB = 2'd1, ACLS_FUNCT = 2'd2} e_aluClass;

    // funct3 values the BRANCH state knows how to evaluate.
    function automatic logic branch_funct3_legal(input logic [2:0] i_funct3);
`ifdef RISCV_BRANCH_EXT_EN
        return (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
`else
        return i_funct3 == 3'b000;
`endif
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request bus between the controller (master) and the shared instruction/data memory (slave).
// Latency: n/a (wires only).
// Backpressure: master holds o_memReq/o_memWriteEn/o_addressSrc stable until the slave raises i_memReady.
interface multicycle_controller_if;
    logic o_memReq;
    logic o_memWriteEn;
    logic o_addressSrc;
    logic i_memReady;

    modport master (output o_memReq, output o_memWriteEn, output o_addressSrc, input i_memReady);
    modport slave  (input o_memReq, input o_memWriteEn, input o_addressSrc, output i_memReady);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the state's ALU class and the instruction funct fields onto an ALU operation.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  e_aluClass   i_aluClass,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7bit5,
    input  logic        i_opb5,
    output logic [3:0]  o_aluLogicOperation
);

    e_aluOp w_op;

    // Select the op; only register-register ops use funct7 bit5 to pick SUB, shifts always do.
    always_comb begin
        w_op = ALU_ADD;
        case (i_aluClass)
            ACLS_SUB: w_op = ALU_SUB;
            ACLS_FUNCT: begin
                case (i_funct3)
                    3'b000:  w_op = (i_opb5 && i_funct7bit5) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_op = ALU_SLL;
                    3'b010:  w_op = ALU_SLT;
                    3'b011:  w_op = ALU_SLTU;
                    3'b100:  w_op = ALU_XOR;
                    3'b101:  w_op = i_funct7bit5 ? ALU_SRA : ALU_SRL;
                    3'b110:  w_op = ALU_OR;
                    default: w_op = ALU_AND;
                endcase
            end
            default: w_op = ALU_ADD;
        endcase
    end

    assign o_aluLogicOperation = w_op;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback with bus timeout and trap state.
// Latency: one state per cycle; FETCH/MEMREAD/MEMWRITE stretch until i_memReady (trap after TIMEOUT_CYCLES).
// Backpressure: memory request held stable until ready. Optional macro RISCV_BRANCH_EXT_EN adds bne..bgeu.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ILLEGAL_TRAP   = 1'b1
)
(
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic [6:0]  i_operand,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7bit5,
    input  logic        i_zeroFlag,
    input  logic        i_lessThanFlag,
    input  logic        i_lessThanUFlag,
    multicycle_controller_if.master io_mem,
    output logic        o_instructionRegWrite,
    output logic        o_pcWriteEn,
    output logic        o_regWriteEn,
    output logic [1:0]  o_aluSrcA,
    output logic [1:0]  o_aluSrcB,
    output logic [1:0]  o_resultSrc,
    output logic [3:0]  o_aluLogicOperation,
    output logic        o_error,
    output logic [3:0]  o_state
);

    localparam int              CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam e_mcState        ILLEGAL_NEXT = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

    e_mcState         r_state;
    e_mcState         w_nextState;
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_error;

    logic             w_memReq;
    logic             w_memWriteEn;
    logic             w_addressSrc;
    logic             w_irWrite;
    logic             w_pcWriteEn;
    logic             w_regWriteEn;
    logic             w_branchTaken;
    logic             w_waitExpired;
    e_aluSrcA         w_aluSrcA;
    e_aluSrcB         w_aluSrcB;
    e_resultSrc       w_resultSrc;
    e_aluClass        w_aluClass;

    // Last permitted unanswered request cycle: no ready now means the bus is considered dead.
    assign w_waitExpired = (r_waitCnt == CNT_LAST);

`ifdef RISCV_BRANCH_EXT_EN
    // Branch condition from funct3 and the comparator flags.
    always_comb begin
        w_branchTaken = 1'b0;
        case (i_funct3)
            3'b000:  w_branchTaken = i_zeroFlag;
            3'b001:  w_branchTaken = !i_zeroFlag;
            3'b100:  w_branchTaken = i_lessThanFlag;
            3'b101:  w_branchTaken = !i_lessThanFlag;
            3'b110:  w_branchTaken = i_lessThanUFlag;
            3'b111:  w_branchTaken = !i_lessThanUFlag;
            default: w_branchTaken = 1'b0;
        endcase
    end
`else
    // Only beq exists, so the comparator flags are not needed.
    logic w_unusedFlags;
    assign w_unusedFlags = i_lessThanFlag ^ i_lessThanUFlag;
    assign w_branchTaken = i_zeroFlag;
`endif

    // Next state and all datapath controls, decoded from the registered state.
    always_comb begin
        w_nextState  = r_state;
        w_memReq     = 1'b0;
        w_memWriteEn = 1'b0;
        w_addressSrc = 1'b0;
        w_irWrite    = 1'b0;
        w_pcWriteEn  = 1'b0;
        w_regWriteEn = 1'b0;
        w_aluSrcA    = SRCA_PC;
        w_aluSrcB    = SRCB_RD2;
        w_resultSrc  = RES_ALUOUT;
        w_aluClass   = ACLS_ADD;
        case (r_state)
            S_FETCH: begin
                w_memReq    = 1'b1;
                w_aluSrcB   = SRCB_CONST4;
                w_resultSrc = RES_ALURESULT;
                if (io_mem.i_memReady) begin
                    w_irWrite   = 1'b1;
                    w_pcWriteEn = 1'b1;
                    w_nextState = S_DECODE;
                end else if (w_waitExpired) begin
                    w_nextState = S_TRAP;
                end
            end
            S_DECODE: begin
                // Branch target OLDPC+imm lands in aluOutput_q for BRANCH to use.
                w_aluSrcA = SRCA_OLDPC;
                w_aluSrcB = SRCB_IMM;
                case (i_operand)
                    OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
                    OP_REG:            w_nextState = S_EXECUTER;
                    OP_IMM:            w_nextState = S_EXECUTEI;
                    OP_BRANCH:         w_nextState = branch_funct3_legal(i_funct3) ? S_BRANCH : ILLEGAL_NEXT;
                    OP_JAL:            w_nextState = S_JAL;
                    default:           w_nextState = ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: begin
                w_aluSrcA   = SRCA_RD1;
                w_aluSrcB   = SRCB_IMM;
                w_nextState = (i_operand == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_memReq     = 1'b1;
                w_addressSrc = 1'b1;
                if (io_mem.i_memReady)  w_nextState = S_MEMWB;
                else if (w_waitExpired) w_nextState = S_TRAP;
            end
            S_MEMWB: begin
                w_regWriteEn = 1'b1;
                w_resultSrc  = RES_DATA;
                w_nextState  = S_FETCH;
            end
            S_MEMWRITE: begin
                w_memReq     = 1'b1;
                w_memWriteEn = 1'b1;
                w_addressSrc = 1'b1;
                if (io_mem.i_memReady)  w_nextState = S_FETCH;
                else if (w_waitExpired) w_nextState = S_TRAP;
            end
            S_EXECUTER: begin
                w_aluSrcA   = SRCA_RD1;
                w_aluSrcB   = SRCB_RD2;
                w_aluClass  = ACLS_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_aluSrcA   = SRCA_RD1;
                w_aluSrcB   = SRCB_IMM;
                w_aluClass  = ACLS_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_ALUWB: begin
                w_regWriteEn = 1'b1;
                w_resultSrc  = RES_ALUOUT;
                w_nextState  = S_FETCH;
            end
            S_BRANCH: begin
                w_aluSrcA   = SRCA_RD1;
                w_aluSrcB   = SRCB_RD2;
                w_aluClass  = ACLS_SUB;
                w_resultSrc = RES_ALUOUT;
                w_pcWriteEn = w_branchTaken;
                w_nextState = S_FETCH;
            end
            S_JAL: begin
                w_aluSrcA    = SRCA_OLDPC;
                w_aluSrcB    = SRCB_CONST4;
                w_resultSrc  = RES_ALUOUT;
                w_pcWriteEn  = 1'b1;
                w_regWriteEn = 1'b1;
                w_nextState  = S_FETCH;
            end
            S_TRAP: begin
                w_nextState = S_TRAP;
            end
            default: begin
                w_nextState = ILLEGAL_NEXT;
            end
        endcase
        // Reset silences every strobe in the same cycle, before the register has settled.
        if (i_srst) begin
            w_nextState  = S_FETCH;
            w_memReq     = 1'b0;
            w_memWriteEn = 1'b0;
            w_addressSrc = 1'b0;
            w_irWrite    = 1'b0;
            w_pcWriteEn  = 1'b0;
            w_regWriteEn = 1'b0;
            w_aluSrcA    = SRCA_PC;
            w_aluSrcB    = SRCB_RD2;
            w_resultSrc  = RES_ALUOUT;
            w_aluClass   = ACLS_ADD;
        end
    end

    alu_decoder u_alu_decoder (
        .i_aluClass          (w_aluClass),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .i_opb5              (i_operand[5]),
        .o_aluLogicOperation (o_aluLogicOperation)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_srst) r_state <= S_FETCH;
        else        r_state <= w_nextState;
    end

    // Unanswered-request counter: restarts on every state change, counts cycles of req without ready.
    always_ff @(posedge i_clk) begin
        if (i_srst || (w_nextState != r_state)) r_waitCnt <= '0;
        else if (w_memReq && !io_mem.i_memReady) r_waitCnt <= r_waitCnt + CNT_W'(1);
    end

    // Sticky error flag, raised together with the move into TRAP.
    always_ff @(posedge i_clk) begin
        if (i_srst)                       r_error <= 1'b0;
        else if (w_nextState == S_TRAP)   r_error <= 1'b1;
    end

    assign io_mem.o_memReq      = w_memReq;
    assign io_mem.o_memWriteEn  = w_memWriteEn;
    assign io_mem.o_addressSrc  = w_addressSrc;
    assign o_instructionRegWrite = w_irWrite;
    assign o_pcWriteEn          = w_pcWriteEn;
    assign o_regWriteEn         = w_regWriteEn;
    assign o_aluSrcA            = w_aluSrcA;
    assign o_aluSrcB            = w_aluSrcB;
    assign o_resultSrc          = w_resultSrc;
    assign o_error              = r_error;
    assign o_state              = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed ISA cases plus randomized instruction stream.
// Latency: expected state sequence per instruction derived from the instruction class and ready delays.
// Backpressure: ready is delayed randomly in FETCH/MEMREAD/MEMWRITE and randomized when no request is up.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam bit         TB_ILLEGAL_TRAP = 1'b1;
    localparam logic [5:0] SB_REQ = 6'b100000;
    localparam logic [5:0] SB_WE  = 6'b010000;
    localparam logic [5:0] SB_AS  = 6'b001000;
    localparam logic [5:0] SB_IRW = 6'b000100;
    localparam logic [5:0] SB_PCW = 6'b000010;
    localparam logic [5:0] SB_RW  = 6'b000001;

    logic       clk = 1'b0;
    logic       srst;
    logic [6:0] operand;
    logic [2:0] funct3;
    logic       funct7bit5, zero_flag, lt_flag, ltu_flag;
    logic       ir_write, pc_write, reg_write, error;
    logic [1:0] src_a, src_b, result_src;
    logic [3:0] alu_op, state;

    multicycle_controller_if mem_if();

    int n_checks  = 0;
    int n_pass    = 0;
    bit model_err = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYCLES(16), .ILLEGAL_TRAP(TB_ILLEGAL_TRAP)) dut (
        .i_clk                 (clk),
        .i_srst                (srst),
        .i_operand             (operand),
        .i_funct3              (funct3),
        .i_funct7bit5          (funct7bit5),
        .i_zeroFlag            (zero_flag),
        .i_lessThanFlag        (lt_flag),
        .i_lessThanUFlag       (ltu_flag),
        .io_mem                (mem_if),
        .o_instructionRegWrite (ir_write),
        .o_pcWriteEn           (pc_write),
        .o_regWriteEn          (reg_write),
        .o_aluSrcA             (src_a),
        .o_aluSrcB             (src_b),
        .o_resultSrc           (result_src),
        .o_aluLogicOperation   (alu_op),
        .o_error               (error),
        .o_state               (state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ISA meaning of funct3/funct7 for arithmetic instructions.
    function automatic int ref_alu_op(input bit is_reg, input logic [2:0] f3, input bit f7);
        case (f3)
            3'd0:    return (is_reg && f7) ? int'(ALU_SUB) : int'(ALU_ADD);
            3'd1:    return int'(ALU_SLL);
            3'd2:    return int'(ALU_SLT);
            3'd3:    return int'(ALU_SLTU);
            3'd4:    return int'(ALU_XOR);
            3'd5:    return f7 ? int'(ALU_SRA) : int'(ALU_SRL);
            3'd6:    return int'(ALU_OR);
            default: return int'(ALU_AND);
        endcase
    endfunction

    // ISA meaning of the branch funct3 codes.
    function automatic bit ref_taken(input logic [2:0] f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            default: return !ltu;
        endcase
    endfunction

    // One cycle: drive ready at the falling edge, compare after settling, move to the next falling edge.
    task automatic step(input e_mcState st, input logic [5:0] strobes, input int a, input int b,
                        input int res, input int op, input bit rdy);
        logic [5:0] seen;
        mem_if.i_memReady = rdy;
        #1;
        seen = {mem_if.o_memReq, mem_if.o_memWriteEn, mem_if.o_addressSrc & mem_if.o_memReq,
                ir_write, pc_write, reg_write};
        check($sformatf("%s.state", st.name()), int'(state), int'(st));
        check($sformatf("%s.strobes", st.name()), int'(seen), int'(strobes));
        check($sformatf("%s.error", st.name()), int'(error), int'(model_err));
        if (a >= 0)   check($sformatf("%s.srcA", st.name()), int'(src_a), a);
        if (b >= 0)   check($sformatf("%s.srcB", st.name()), int'(src_b), b);
        if (res >= 0) check($sformatf("%s.result", st.name()), int'(result_src), res);
        if (op >= 0)  check($sformatf("%s.aluop", st.name()), int'(alu_op), op);
        @(negedge clk);
    endtask

    task automatic illegal_next();
        e_mcState nxt;
        nxt = TB_ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        model_err = model_err | TB_ILLEGAL_TRAP;
        step(nxt, (nxt == S_FETCH) ? SB_REQ : 6'b0, -1, -1, -1, -1, 1'b0);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mem_if.i_memReady = rbit();
            #1;
            check("rst.strobes", int'({mem_if.o_memReq, mem_if.o_memWriteEn, ir_write, pc_write, reg_write}), 0);
            check("rst.selects", int'({src_a, src_b, result_src}), 0);
            check("rst.aluop", int'(alu_op), int'(ALU_ADD));
            @(negedge clk);
        end
        srst = 1'b0;
        model_err = 1'b0;
    endtask

    // Walk one instruction through the expected state path, with fdel/mdel unanswered request cycles.
    task automatic run_instr(input logic [31:0] ins, input bit z, input bit lt, input bit ltu,
                             input int fdel, input int mdel);
        logic [6:0] opc;
        logic [2:0] f3;
        bit         f7;
        bit         legal;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[30];
        operand = opc; funct3 = f3; funct7bit5 = f7;
        zero_flag = z; lt_flag = lt; ltu_flag = ltu;
        for (int k = 0; k <= fdel; k++)
            step(S_FETCH, (k == fdel) ? (SB_REQ | SB_IRW | SB_PCW) : SB_REQ, int'(SRCA_PC),
                 int'(SRCB_CONST4), int'(RES_ALURESULT), int'(ALU_ADD), k == fdel);
        step(S_DECODE, 6'b0, int'(SRCA_OLDPC), int'(SRCB_IMM), -1, int'(ALU_ADD), rbit());
        case (opc)
            OP_LOAD: begin
                step(S_MEMADR, 6'b0, int'(SRCA_RD1), int'(SRCB_IMM), -1, int'(ALU_ADD), rbit());
                for (int k = 0; k <= mdel; k++) step(S_MEMREAD, SB_REQ | SB_AS, -1, -1, -1, -1, k == mdel);
                step(S_MEMWB, SB_RW, -1, -1, int'(RES_DATA), -1, rbit());
            end
            OP_STORE: begin
                step(S_MEMADR, 6'b0, int'(SRCA_RD1), int'(SRCB_IMM), -1, int'(ALU_ADD), rbit());
                for (int k = 0; k <= mdel; k++)
                    step(S_MEMWRITE, SB_REQ | SB_WE | SB_AS, -1, -1, -1, -1, k == mdel);
            end
            OP_REG: begin
                step(S_EXECUTER, 6'b0, int'(SRCA_RD1), int'(SRCB_RD2), -1, ref_alu_op(1'b1, f3, f7), rbit());
                step(S_ALUWB, SB_RW, -1, -1, int'(RES_ALUOUT), -1, rbit());
            end
            OP_IMM: begin
                step(S_EXECUTEI, 6'b0, int'(SRCA_RD1), int'(SRCB_IMM), -1, ref_alu_op(1'b0, f3, f7), rbit());
                step(S_ALUWB, SB_RW, -1, -1, int'(RES_ALUOUT), -1, rbit());
            end
            OP_BRANCH: begin
`ifdef RISCV_BRANCH_EXT_EN
                legal = (f3 != 3'd2) && (f3 != 3'd3);
`else
                legal = (f3 == 3'd0);
`endif
                if (legal)
                    step(S_BRANCH, ref_taken(f3, z, lt, ltu) ? SB_PCW : 6'b0, int'(SRCA_RD1),
                         int'(SRCB_RD2), int'(RES_ALUOUT), int'(ALU_SUB), rbit());
                else
                    illegal_next();
            end
            OP_JAL: step(S_JAL, SB_PCW | SB_RW, int'(SRCA_OLDPC), int'(SRCB_CONST4),
                         int'(RES_ALUOUT), -1, rbit());
            default: illegal_next();
        endcase
    endtask

    logic [2:0] branch_f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        logic [31:0] ins;
        srst = 1'b1;
        operand = 7'd0; funct3 = 3'd0; funct7bit5 = 1'b0;
        zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;
        mem_if.i_memReady = 1'b0;
        @(negedge clk);
        do_reset();

        run_instr(32'h00500093, 1'b0, 1'b0, 1'b0, 0, 0);   // addi x1,x0,5
        run_instr(32'h00002083, 1'b0, 1'b0, 1'b0, 3, 3);   // lw x1,0(x0), slow memory
        run_instr(32'h00000063, 1'b1, 1'b0, 1'b0, 0, 0);   // beq taken
        run_instr(32'h00000063, 1'b0, 1'b0, 1'b0, 1, 0);   // beq not taken

        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0: ins[6:0] = OP_LOAD;
                1: ins[6:0] = OP_STORE;
                2: ins[6:0] = OP_REG;
                3: ins[6:0] = OP_IMM;
                4: begin
                    ins[6:0] = OP_BRANCH;
`ifdef RISCV_BRANCH_EXT_EN
                    ins[14:12] = branch_f3s[$urandom_range(0, 5)];
`else
                    ins[14:12] = branch_f3s[0];
`endif
                end
                default: ins[6:0] = OP_JAL;
            endcase
            run_instr(ins, rbit(), rbit(), rbit(), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Ready arrives in the 16th request cycle: must still complete.
        run_instr(32'h00500093, 1'b0, 1'b0, 1'b0, 15, 0);

        // Reset in the middle of a stalled store.
        operand = OP_STORE; funct3 = 3'd2; funct7bit5 = 1'b0;
        step(S_FETCH, SB_REQ | SB_IRW | SB_PCW, -1, -1, -1, -1, 1'b1);
        step(S_DECODE, 6'b0, -1, -1, -1, -1, 1'b0);
        step(S_MEMADR, 6'b0, -1, -1, -1, -1, 1'b0);
        step(S_MEMWRITE, SB_REQ | SB_WE | SB_AS, -1, -1, -1, -1, 1'b0);
        do_reset();
        run_instr(32'h00500093, 1'b0, 1'b0, 1'b0, 0, 0);

        // Ready never arrives in FETCH: 16 request cycles, then TRAP, sticky.
        operand = OP_IMM;
        for (int k = 0; k < 16; k++)
            step(S_FETCH, SB_REQ, int'(SRCA_PC), int'(SRCB_CONST4), int'(RES_ALURESULT), int'(ALU_ADD), 1'b0);
        model_err = 1'b1;
        for (int k = 0; k < 3; k++) step(S_TRAP, 6'b0, -1, -1, -1, -1, rbit());
        do_reset();

        // Unknown opcode.
        run_instr(32'h0000007F, 1'b0, 1'b0, 1'b0, 0, 0);
        step(TB_ILLEGAL_TRAP ? S_TRAP : S_FETCH, TB_ILLEGAL_TRAP ? 6'b0 : SB_REQ, -1, -1, -1, -1, 1'b0);
        do_reset();

        // bne with zero=0: taken with the extended set, illegal without it.
        run_instr(32'h00001063, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset();
        run_instr(32'h00500093, 1'b0, 1'b0, 1'b0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
